// File: rtl/display_scanner_pkg.sv
// Shared definitions for the register-file display scanner.
//   state_e      : scanner FSM encoding (IDLE -> REQ -> WAIT -> IDLE)
//   TIMEOUT_FILL : data shown when a read never returns
//   DISP_PAD     : upper bits of the 32-bit display word
//   pack_word()  : builds {pad, register index, register data}
package display_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_FILL = 16'hDEAD;
  localparam logic [11:0] DISP_PAD     = 12'h000;

  function automatic logic [31:0] pack_word(input logic [3:0]  idx,
                                            input logic [15:0] data);
    return {DISP_PAD, idx, data};
  endfunction

endpackage

// File: rtl/display_scanner_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, debounce counter and
// rising-edge pulse on the debounced level.
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset
//   btn_i   : raw asynchronous button input
//   pulse_o : one-cycle pulse when the debounced level goes 0 -> 1
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q counts consecutive synchronized samples that disagree with the
  // stable level; any agreeing sample (a bounce back) restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
      pulse_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/display_scanner.sv
// Register-file scanner feeding the 8-digit seven-segment controller.
// Steps through the register file on a debounced button or timer tick,
// issues one read per step and packs {index, data} into the display word.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   step_btn  : raw button, advance to the next register
//   auto_en   : 1 = ticks advance the index, 0 = ticks re-read it
//   freeze    : 1 = no new reads issued, events discarded
//   rd_en     : one-cycle read strobe
//   rd_addr   : register index under read
//   rd_data   : register file data
//   rd_valid  : rd_data valid strobe
//   disp_word : {12'h000, index, data} for the display controller
//   busy      : read in flight (REQ or WAIT)
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int DATA_W       = 16,  // display packing assumes 16
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TICK_CYC     = 100_000_000,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step_btn,
  input  logic              auto_en,
  input  logic              freeze,
  output logic              rd_en,
  output logic [3:0]        rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_valid,
  output logic [31:0]       disp_word,
  output logic              busy
);

  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int OW = $clog2(TIMEOUT_CYC + 1);

  function automatic logic [3:0] next_index(input logic [3:0] i);
    if (i == 4'(NUM_REGS - 1)) return 4'd0;
    return i + 4'd1;
  endfunction

  state_e        state_q, state_d;
  logic [3:0]    index_q, index_d;
  logic [31:0]   disp_q, disp_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] to_q, to_d;
  logic          pend_q, pend_d;
  logic          init_q, init_d;
  logic          tick;
  logic          step;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn (
    .clk_i   (clk),
    .rst_ni  (reset),
    .btn_i   (step_btn),
    .pulse_o (step)
  );

  // Free-running timer; events never restart it.
  always_comb begin
    tick   = (tick_q == TW'(TICK_CYC - 1));
    tick_d = tick ? '0 : tick_q + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    disp_d  = disp_q;
    to_d    = to_q;
    pend_d  = pend_q;
    init_d  = init_q;
    unique case (state_q)
      ST_IDLE: begin
        if (freeze) begin
          // init_req survives a freeze so the first read still happens.
          pend_d = 1'b0;
        end else if (init_q || pend_q || step) begin
          if (!init_q) index_d = next_index(index_q);
          init_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_REQ;
        end else if (tick) begin
          if (auto_en) index_d = next_index(index_q);
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (step) pend_d = 1'b1;
        to_d    = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (step) pend_d = 1'b1;
        if (rd_valid) begin
          disp_d  = pack_word(index_q, rd_data);
          state_d = ST_IDLE;
        end else if (to_q == OW'(TIMEOUT_CYC - 1)) begin
          disp_d  = pack_word(index_q, TIMEOUT_FILL);
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      disp_q  <= '0;
      tick_q  <= '0;
      to_q    <= '0;
      pend_q  <= 1'b0;
      init_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      disp_q  <= disp_d;
      tick_q  <= tick_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
      init_q  <= init_d;
    end
  end

  // index only changes on the IDLE->REQ transition, so rd_addr is stable
  // for the whole read.
  assign rd_en     = (state_q == ST_REQ);
  assign rd_addr   = index_q;
  assign busy      = (state_q != ST_IDLE);
  assign disp_word = disp_q;

endmodule

// File: tb/tb_display_scanner.sv
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        step_btn = 1'b0;
  logic        auto_en = 1'b0;
  logic        freeze = 1'b0;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data = '0;
  logic        rd_valid = 1'b0;
  logic [31:0] disp_word;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] ram [16];
  logic        ram_on = 1'b1;
  logic [3:0]  idx_m = '0;
  logic [31:0] last_disp = '0;
  logic [3:0]  addr_q [$];
  logic [31:0] disp_q [$];

  always #5 clk = ~clk;

  display_scanner #(
    .NUM_REGS(16), .DATA_W(16), .DEBOUNCE_CYC(4), .TICK_CYC(1000), .TIMEOUT_CYC(40)
  ) dut (
    .clk(clk), .reset(rst_n), .step_btn(step_btn), .auto_en(auto_en),
    .freeze(freeze), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .disp_word(disp_word), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 1-cycle register file: rd_valid is high in the cycle after rd_en.
  initial begin
    logic       resp;
    logic [3:0] a;
    resp = 1'b0;
    a = '0;
    forever begin
      @(negedge clk);
      rd_valid = 1'b0;
      if (!rst_n) resp = 1'b0;
      else begin
        if (resp) begin
          rd_valid = 1'b1;
          rd_data  = ram[a];
          resp     = 1'b0;
        end
        if (rd_en && ram_on) begin
          resp = 1'b1;
          a    = rd_addr;
        end
      end
    end
  end

  // Monitor: every read strobe and every completed read is checked
  // against the queued expectations.
  initial begin
    logic        prev_busy;
    logic [3:0]  ea;
    logic [31:0] ed;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) prev_busy = 1'b0;
      else begin
        if (rd_en) begin
          if (addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rd_en: got addr %0d expected no request", rd_addr);
          end else begin
            ea = addr_q.pop_front();
            chk("rd_addr", {28'h0, rd_addr}, {28'h0, ea});
          end
        end
        if (prev_busy && !busy) begin
          if (disp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_completion: got disp %h expected no read", disp_word);
          end else begin
            ed = disp_q.pop_front();
            chk("disp_word", disp_word, ed);
          end
        end
        prev_busy = busy;
      end
    end
  end

  task automatic expect_read(input logic [3:0] idx, input logic timeout);
    logic [31:0] d;
    d = timeout ? {12'h000, idx, 16'hDEAD} : {12'h000, idx, ram[idx]};
    addr_q.push_back(idx);
    disp_q.push_back(d);
    last_disp = d;
    idx_m = idx;
  endtask

  task automatic press();
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((addr_q.size() != 0 || disp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got %0d reads outstanding expected 0", name, disp_q.size());
      addr_q.delete();
      disp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) ram[i] = 16'h1000 + 16'(i);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rd_en", {31'h0, rd_en}, 32'h0);
    chk("reset_rd_addr", {28'h0, rd_addr}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_disp", disp_word, 32'h0);

    // Initial read of register 0 after release
    expect_read(4'd0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_rd_en", {31'h0, rd_en}, 32'h1);
    wait_idle("init", 20);
    chk("init_disp", disp_word, 32'h0000_1000);
    chk("init_busy", {31'h0, busy}, 32'h0);

    // Bouncy press gives exactly one advance
    expect_read(4'd1, 1'b0);
    step_btn = 1'b1; @(negedge clk);
    step_btn = 1'b0; @(negedge clk);
    step_btn = 1'b1; @(negedge clk);
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    repeat (10) @(negedge clk);
    wait_idle("bounce", 40);
    chk("bounce_disp", disp_word, 32'h0001_1001);

    // Presses up to 15 and wrap to 0
    for (int i = 2; i <= 16; i++) begin
      expect_read(4'(i), 1'b0);
      press();
      wait_idle("wrap", 40);
    end
    chk("wrap_disp", disp_word, 32'h0000_1000);

    // Tick refresh with auto_en=0, then auto advance on two ticks
    expect_read(idx_m, 1'b0);
    wait_idle("tick_refresh", 1200);
    auto_en = 1'b1;
    expect_read(4'd1, 1'b0);
    wait_idle("auto1", 1200);
    expect_read(4'd2, 1'b0);
    wait_idle("auto2", 1200);
    auto_en = 1'b0;
    chk("auto_disp", disp_word, 32'h0002_1002);

    // Refresh picks up changed data at index 3
    expect_read(4'd3, 1'b0);
    press();
    wait_idle("step3", 40);
    ram[3] = 16'hBEEF;
    expect_read(4'd3, 1'b0);
    wait_idle("refresh3", 1200);
    chk("refresh_disp", disp_word, 32'h0003_BEEF);

    // Read that never returns
    ram_on = 1'b0;
    expect_read(4'd4, 1'b1);
    press();
    wait_idle("timeout", 100);
    chk("timeout_disp", disp_word, 32'h0004_DEAD);
    ram_on = 1'b1;
    expect_read(4'd5, 1'b0);
    press();
    wait_idle("after_timeout", 40);
    chk("after_timeout_disp", disp_word, 32'h0005_1005);

    // Press during WAIT is held pending and issued right after IDLE
    ram_on = 1'b0;
    expect_read(4'd6, 1'b1);
    expect_read(4'd7, 1'b0);
    press();
    ram_on = 1'b1;
    step_btn = 1'b1;
    repeat (10) @(negedge clk);
    step_btn = 1'b0;
    n = 0;
    while (busy && n < 100) begin @(negedge clk); n++; end
    chk("pending_idle_seen", {31'h0, busy}, 32'h0);
    @(negedge clk);
    chk("pending_rd_en", {31'h0, rd_en}, 32'h1);
    wait_idle("pending", 60);
    chk("pending_disp", disp_word, 32'h0007_1007);

    // Freeze discards presses
    freeze = 1'b1;
    press();
    press();
    freeze = 1'b0;
    repeat (20) @(negedge clk);
    chk("freeze_disp", disp_word, last_disp);
    chk("freeze_busy", {31'h0, busy}, 32'h0);

    // Reset during WAIT clears outputs immediately
    ram_on = 1'b0;
    addr_q.push_back(4'd8);
    step_btn = 1'b1;
    n = 0;
    while (!rd_en && n < 40) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("mid_busy_before_reset", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_reset_disp", disp_word, 32'h0);
    chk("mid_reset_busy", {31'h0, busy}, 32'h0);
    chk("mid_reset_rd_en", {31'h0, rd_en}, 32'h0);
    chk("mid_reset_rd_addr", {28'h0, rd_addr}, 32'h0);
    step_btn = 1'b0;
    ram_on = 1'b1;
    addr_q.delete();
    disp_q.delete();
    repeat (3) @(negedge clk);
    expect_read(4'd0, 1'b0);
    rst_n = 1'b1;
    wait_idle("rerun", 20);
    chk("rerun_disp", disp_word, 32'h0000_1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
